// File: rtl/audio_cic_interp.sv
// CIC interpolator: comb stages at the input sample rate, zero-stuffing, then
// integrator stages at the output rate gated by the mixer's clock enable.
module audio_cic_interp #(
    parameter int IW     = 16,
    parameter int STAGES = 3,
    parameter int RATE   = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cen,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [IW-1:0] snd_in,
    output logic                 out_valid,
    output logic signed [IW-1:0] snd_out,
    output logic                 underrun
);

    localparam int LOG2R = $clog2(RATE);
    localparam int CALCW = IW + STAGES * LOG2R;
    localparam int SHIFT = (STAGES - 1) * LOG2R;
    localparam logic [LOG2R-1:0] PHASE_LAST = LOG2R'(RATE - 1);
    localparam logic [LOG2R-1:0] PHASE_ZERO = {LOG2R{1'b0}};

    logic [LOG2R-1:0]        phase_r;
    logic signed [IW-1:0]    buf_r;
    logic                    buf_full_r;
    logic signed [IW-1:0]    last_in_r;
    logic signed [CALCW-1:0] comb_d_r [STAGES];
    logic signed [CALCW-1:0] comb_out_r;
    logic signed [CALCW-1:0] integ_r [STAGES];
    logic signed [IW-1:0]    snd_out_r;
    logic                    out_valid_r;
    logic                    underrun_r;

    logic                    update_s;
    logic                    load_s;
    logic signed [IW-1:0]    x_s;
    logic signed [CALCW-1:0] comb_in_s [STAGES];
    logic signed [CALCW-1:0] comb_res_s;
    logic signed [CALCW-1:0] integ_u_s;

    // Low-rate sample selection, comb chain and zero-stuffed integrator input.
    always_comb begin
        logic signed [CALCW-1:0] acc_v;
        update_s = cen && (phase_r == PHASE_ZERO);
        load_s   = in_valid && !buf_full_r;
        if (buf_full_r) begin
            x_s = buf_r;
        end else begin
            x_s = last_in_r;
        end
        if (phase_r == PHASE_ZERO) begin
            integ_u_s = comb_out_r;
        end else begin
            integ_u_s = {CALCW{1'b0}};
        end
        acc_v = {{(CALCW - IW){x_s[IW-1]}}, x_s};
        for (int k = 0; k < STAGES; k++) begin
            comb_in_s[k] = acc_v;
            acc_v        = acc_v - comb_d_r[k];
        end
        comb_res_s = acc_v;
    end

    // Phase counter, one-entry input buffer, held sample and sticky underrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_r    <= PHASE_ZERO;
            buf_r      <= {IW{1'b0}};
            buf_full_r <= 1'b0;
            last_in_r  <= {IW{1'b0}};
            underrun_r <= 1'b0;
        end else begin
            if (cen) begin
                phase_r <= (phase_r == PHASE_LAST) ? PHASE_ZERO : phase_r + {{(LOG2R-1){1'b0}}, 1'b1};
            end
            // An empty buffer at the update lets a new sample land on the same edge.
            if (load_s) begin
                buf_r      <= snd_in;
                buf_full_r <= 1'b1;
            end else if (update_s) begin
                buf_full_r <= 1'b0;
            end
            if (update_s) begin
                last_in_r <= x_s;
                if (!buf_full_r) begin
                    underrun_r <= 1'b1;
                end
            end
        end
    end

    // Comb delays (input rate) and integrators (output rate), modular CALCW arithmetic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                comb_d_r[k] <= {CALCW{1'b0}};
                integ_r[k]  <= {CALCW{1'b0}};
            end
            comb_out_r <= {CALCW{1'b0}};
        end else begin
            if (update_s) begin
                for (int k = 0; k < STAGES; k++) begin
                    comb_d_r[k] <= comb_in_s[k];
                end
                comb_out_r <= comb_res_s;
            end
            if (cen) begin
                integ_r[0] <= integ_r[0] + integ_u_s;
                for (int k = 1; k < STAGES; k++) begin
                    integ_r[k] <= integ_r[k] + integ_r[k-1];
                end
            end
        end
    end

    // Output scaling drops RATE^(STAGES-1) of gain; the slice is the arithmetic shift.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snd_out_r   <= {IW{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= cen;
            if (cen) begin
                snd_out_r <= integ_r[STAGES-1][SHIFT +: IW];
            end
        end
    end

    assign in_ready  = ~buf_full_r;
    assign out_valid = out_valid_r;
    assign snd_out   = snd_out_r;
    assign underrun  = underrun_r;

endmodule

// File: tb/tb_audio_cic_interp.sv
// Bench for audio_cic_interp: impulse table, DC steps, handshake, underrun,
// randomized traffic against a convolution model, and two parameter sweeps.
module tb_audio_cic_interp;

    localparam int R0  = 4;
    localparam int N0  = 3;
    localparam int SH0 = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic cen = 1'b0, in_valid = 1'b0;
    logic signed [15:0] snd_in = 16'sd0;
    logic in_ready, out_valid, underrun;
    logic signed [15:0] snd_out;

    logic cen1 = 1'b0, v1 = 1'b0;
    logic signed [15:0] d1 = 16'sd0;
    logic in_ready1, out_valid1, underrun1;
    logic signed [15:0] snd_out1;

    logic cen5 = 1'b0, v5 = 1'b0;
    logic signed [15:0] d5 = 16'sd0;
    logic in_ready5, out_valid5, underrun5;
    logic signed [15:0] snd_out5;

    audio_cic_interp #(.IW(16), .STAGES(3), .RATE(4)) dut (
        .clk(clk), .reset_n(reset_n), .cen(cen), .in_valid(in_valid), .in_ready(in_ready),
        .snd_in(snd_in), .out_valid(out_valid), .snd_out(snd_out), .underrun(underrun));

    audio_cic_interp #(.IW(16), .STAGES(1), .RATE(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .cen(cen1), .in_valid(v1), .in_ready(in_ready1),
        .snd_in(d1), .out_valid(out_valid1), .snd_out(snd_out1), .underrun(underrun1));

    audio_cic_interp #(.IW(16), .STAGES(5), .RATE(64)) dut5 (
        .clk(clk), .reset_n(reset_n), .cen(cen5), .in_valid(v5), .in_ready(in_ready5),
        .snd_in(d5), .out_valid(out_valid5), .snd_out(snd_out5), .underrun(underrun5));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: buffer rules plus output = zero-stuffed input convolved
    // with the CIC impulse response (boxcar of length RATE, raised to STAGES).
    int      h[$];
    longint  xs[$];
    int      cen_cnt;
    int      m_loads;
    logic signed [15:0] m_buf, m_last;
    bit      m_full, m_underrun, m_ov;
    longint  m_out;

    typedef struct {
        logic signed [15:0] sample;
        logic signed [15:0] exp_out;
    } imp_vec_t;
    imp_vec_t tbl [20];

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic build_h();
        h.delete();
        h.push_back(1);
        for (int s = 0; s < N0; s++) begin
            int nh[$];
            for (int i = 0; i < h.size() + R0 - 1; i++) nh.push_back(0);
            for (int i = 0; i < h.size(); i++)
                for (int j = 0; j < R0; j++) nh[i+j] += h[i];
            h = nh;
        end
    endtask

    function automatic longint model_y(input int t);
        longint s = 0;
        if (t < 0) return 0;
        for (int j = 0; j < h.size(); j++) begin
            int tt = t - j;
            if (tt >= 0 && (tt % R0) == 0 && (tt / R0) < xs.size())
                s += longint'(h[j]) * xs[tt / R0];
        end
        return s >>> SH0;
    endfunction

    task automatic model_reset();
        xs.delete();
        cen_cnt = 0; m_loads = 0;
        m_buf = 16'sd0; m_last = 16'sd0;
        m_full = 1'b0; m_underrun = 1'b0; m_ov = 1'b0; m_out = 0;
    endtask

    task automatic step(input bit c, input bit v, input logic signed [15:0] d);
        logic signed [15:0] x;
        bit pre_full;
        cen = c; in_valid = v; snd_in = d;
        @(posedge clk);
        pre_full = m_full;
        if (c) begin
            if ((cen_cnt % R0) == 0) begin
                if (m_full) x = m_buf;
                else begin x = m_last; m_underrun = 1'b1; end
                xs.push_back(longint'(x));
                m_last = x;
                m_full = 1'b0;
            end
            m_out = model_y(cen_cnt - R0 - N0);
            cen_cnt++;
        end
        if (v && !pre_full) begin m_buf = d; m_full = 1'b1; m_loads++; end
        m_ov = c;
        #1;
        chk("snd_out", snd_out, m_out);
        chk("out_valid", out_valid, m_ov);
        chk("in_ready", in_ready, !m_full);
        chk("underrun", underrun, m_underrun);
    endtask

    task automatic do_reset();
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_snd_out", snd_out, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_underrun", underrun, 0);
        cen = 1'b1; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cen = 1'b0; in_valid = 1'b0;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic run_dc(input logic signed [15:0] val);
        longint prev, cur;
        do_reset();
        prev = 0;
        for (int c = 0; c < 30; c++) begin
            step(1'b0, 1'b1, val);
            step(1'b1, 1'b1, val);
            cur = snd_out;
            chk("dc_monotonic", (val < 0) ? (cur <= prev) : (cur >= prev), 1);
            if (c >= 16) chk("dc_settle", cur, val);
            prev = cur;
        end
    endtask

    initial begin
        int imp[10] = '{256, 768, 1536, 2560, 3072, 3072, 2560, 1536, 768, 256};
        int exp1[7] = '{0, 0, 0, 100, 100, 0, 0};
        int acc;
        longint prev, cur;

        build_h();
        for (int e = 0; e < 20; e++) begin
            tbl[e].sample  = (e == 0) ? 16'sd4096 : 16'sd0;
            tbl[e].exp_out = (e >= 7 && e < 17) ? 16'(imp[e-7]) : 16'sd0;
        end

        do_reset();

        // Impulse response, one record per output-rate cen.
        for (int e = 0; e < 20; e++) begin
            if ((e % R0) == 0) step(1'b0, 1'b1, tbl[e].sample);
            step(1'b1, 1'b0, 16'sd0);
            chk("impulse", snd_out, tbl[e].exp_out);
            step(1'b0, 1'b0, 16'sd0);
        end

        run_dc(-16'sd1000);
        run_dc(16'sd32767);

        // Continuous in_valid: one acceptance per RATE cens, plus the refill.
        do_reset();
        acc = 0;
        for (int c = 0; c < 40; c++) begin
            repeat ($urandom_range(1, 3)) begin
                if (in_ready) acc++;
                step(1'b0, 1'b1, 16'($urandom()));
            end
            if (in_ready) acc++;
            step(1'b1, 1'b1, 16'($urandom()));
        end
        if (in_ready) acc++;
        step(1'b0, 1'b1, 16'($urandom()));
        chk("hs_accepted", acc, 11);
        chk("hs_model_loads", acc, m_loads);

        // Starvation after a single sample.
        do_reset();
        step(1'b0, 1'b1, 16'sd500);
        step(1'b1, 1'b0, 16'sd0);
        for (int c = 1; c < 20; c++) begin
            step(1'b0, 1'b0, 16'sd0);
            step(1'b1, 1'b0, 16'sd0);
            chk("underrun_flag", underrun, (c >= 4) ? 1 : 0);
        end
        chk("underrun_hold", snd_out, 500);

        // Randomized traffic with periodic starvation windows.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit c, v;
            c = ($urandom_range(0, 2) == 0);
            v = ((i % 600) < 480) ? ($urandom_range(0, 3) != 0) : 1'b0;
            step(c, v, 16'($urandom()));
        end

        // Reset in the middle of activity, then cold behaviour again.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1) == 1, 1'b1, 16'($urandom()));
        end
        cen = 1'b0; in_valid = 1'b0;

        // STAGES=1, RATE=2 impulse.
        @(negedge clk);
        v1 = 1'b1; d1 = 16'sd100;
        @(negedge clk);
        v1 = 1'b0;
        for (int c = 0; c < 7; c++) begin
            if ((c % 2) == 0 && c > 0) begin
                v1 = 1'b1; d1 = 16'sd0;
                @(negedge clk);
                v1 = 1'b0;
            end
            cen1 = 1'b1;
            @(negedge clk);
            cen1 = 1'b0;
            chk("s1r2_impulse", snd_out1, exp1[c]);
            if (c == 3) chk("s1r2_out_valid", out_valid1, 1);
            @(negedge clk);
        end
        chk("s1r2_underrun", underrun1, 0);

        // STAGES=5, RATE=64 DC step.
        v5 = 1'b1; d5 = 16'sd12345;
        prev = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            cen5 = 1'b1;
            @(negedge clk);
            cen5 = 1'b0;
            cur = snd_out5;
            if ((c % 50) == 0 || c >= 560) chk("s5r64_monotonic", cur >= prev, 1);
            if (c >= 560) chk("s5r64_settle", cur, 12345);
            prev = cur;
        end
        chk("s5r64_underrun", underrun5, 0);
        v5 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
